// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
//   Shared constants for the counter controller: default parameter values,
//   FSM state encoding (the low two bits of IDLE/RUN/PAUSE/DONE match the
//   state_LED encoding) and a helper that maps a state to its LED code.
package counter_ctrl_pkg;

    localparam int DB_CYCLES_DEF  = 1_000_000;  // 20 ms at 50 MHz
    localparam int CLR_CYCLES_DEF = 4;
    localparam int MAX_ROUNDS_DEF = 3;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;

    // CLEAR has no LED code of its own and shows as 0.
    function automatic logic [1:0] state_led(input state_t st);
        if (st == ST_CLEAR) begin
            return 2'd0;
        end
        return st[1:0];
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if
//   Controller <-> timer bus.
//   wrap_pulse   : timer -> controller, one-clk pulse on timer rollover
//   timer_en     : controller -> timer, count enable
//   timer_modulo : controller -> timer, latched modulo select
//   timer_clr_N  : controller -> timer, active-low clear
//   There is no valid/ready handshake on this bus: every signal is a level
//   or a single-cycle pulse sampled on every rising clk edge.
interface counter_ctrl_if;

    logic wrap_pulse;
    logic timer_en;
    logic timer_modulo;
    logic timer_clr_N;

    modport master (
        input  wrap_pulse,
        output timer_en,
        output timer_modulo,
        output timer_clr_N
    );

    modport slave (
        output wrap_pulse,
        input  timer_en,
        input  timer_modulo,
        input  timer_clr_N
    );

endinterface

// File: rtl/counter_ctrl_key_debounce.sv
// key_debounce
//   Debounces one raw active-low pushbutton.
//   clk, rst_N : clock and asynchronous active-low reset
//   key_N      : raw key level, asynchronous to clk
//   press      : one-cycle pulse when the debounced level falls 1 -> 0
//   The raw key passes a 2-FF synchronizer; the debounced level follows the
//   synchronized level only after DB_CYCLES consecutive cycles of
//   disagreement. Any return to agreement restarts the count, so bounce
//   shorter than DB_CYCLES never changes the level.
module key_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_N,
    input  logic key_N,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                // Only the released->pressed transition is an event.
                press_d = level_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer resets to the released level so reset release can never
    // look like a press.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_N;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Start/pause/clear controller for an external round timer.
//   clk, rst_N   : clock and asynchronous active-low reset
//   key_start_N  : raw start/pause pushbutton (active-low)
//   key_clear_N  : raw clear pushbutton (active-low)
//   modulo_SW    : raw modulo select switch, latched on IDLE -> RUN
//   tmr          : timer bus (wrap_pulse in; timer_en/modulo/clr_N out)
//   round_cnt    : wraps counted in the current run, saturates at MAX_ROUNDS
//   state_LED    : IDLE=0, RUN=1, PAUSE=2, DONE=3 (CLEAR shows 0)
//   done_LED     : high only in DONE
//   state_dbg    : raw FSM state, including CLEAR (=4)
//   All outputs are registered from the next-state logic, so they change on
//   the same edge as the state register.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF,
    parameter int MAX_ROUNDS = MAX_ROUNDS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_N,
    input  logic                 key_start_N,
    input  logic                 key_clear_N,
    input  logic                 modulo_SW,
    counter_ctrl_if.master       tmr,
    output logic [1:0]           round_cnt,
    output logic [1:0]           state_LED,
    output logic                 done_LED,
    output logic [2:0]           state_dbg
);

    localparam int              CCW       = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CCW-1:0]  CLR_LAST  = CCW'(CLR_CYCLES - 1);
    localparam logic [1:0]      ROUND_MAX = 2'(MAX_ROUNDS);

    logic           start_ev, clear_ev;
    logic           mod_sync1_q, mod_sync2_q;

    state_t         state_q, state_d;
    logic [1:0]     round_q, round_d, round_inc;
    logic [CCW-1:0] clr_cnt_q, clr_cnt_d;
    logic           modulo_q, modulo_d;

    logic           timer_en_q, timer_clr_n_q, done_q;
    logic [1:0]     led_q;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
        .clk   (clk),
        .rst_N (rst_N),
        .key_N (key_start_N),
        .press (start_ev)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear_db (
        .clk   (clk),
        .rst_N (rst_N),
        .key_N (key_clear_N),
        .press (clear_ev)
    );

    // Saturating increment; in practice RUN leaves before reaching the cap.
    assign round_inc = (round_q == ROUND_MAX) ? round_q : round_q + 2'd1;

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        clr_cnt_d = clr_cnt_q;
        modulo_d  = modulo_q;
        if (clear_ev) begin
            // Clear beats start, and re-entering CLEAR restarts its period.
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            round_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ev) begin
                        state_d  = ST_RUN;
                        modulo_d = mod_sync2_q;
                    end
                end
                ST_RUN: begin
                    if (tmr.wrap_pulse) begin
                        round_d = round_inc;
                        // Reaching the final round beats a coincident start.
                        if (round_inc == ROUND_MAX) begin
                            state_d = ST_DONE;
                        end else if (start_ev) begin
                            state_d = ST_PAUSE;
                        end
                    end else if (start_ev) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start_ev) begin
                        state_d = ST_RUN;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d   = ST_IDLE;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
                default: begin
                    // DONE: only a clear event leaves.
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            mod_sync1_q   <= 1'b0;
            mod_sync2_q   <= 1'b0;
            state_q       <= ST_IDLE;
            round_q       <= 2'd0;
            clr_cnt_q     <= '0;
            modulo_q      <= 1'b0;
            timer_en_q    <= 1'b0;
            timer_clr_n_q <= 1'b1;
            done_q        <= 1'b0;
            led_q         <= 2'd0;
        end else begin
            mod_sync1_q   <= modulo_SW;
            mod_sync2_q   <= mod_sync1_q;
            state_q       <= state_d;
            round_q       <= round_d;
            clr_cnt_q     <= clr_cnt_d;
            modulo_q      <= modulo_d;
            timer_en_q    <= (state_d == ST_RUN);
            timer_clr_n_q <= (state_d != ST_CLEAR);
            done_q        <= (state_d == ST_DONE);
            led_q         <= state_led(state_d);
        end
    end

    assign tmr.timer_en     = timer_en_q;
    assign tmr.timer_modulo = modulo_q;
    assign tmr.timer_clr_N  = timer_clr_n_q;
    assign round_cnt        = round_q;
    assign state_LED        = led_q;
    assign done_LED         = done_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl
//   Directed bench for counter_ctrl with DB_CYCLES=4, CLR_CYCLES=3,
//   MAX_ROUNDS=2. Inputs change 1 ns after the rising edge and outputs are
//   sampled at that same point, after the edge has settled.
`timescale 1ns/1ps
module tb_counter_ctrl;

    logic       clk;
    logic       rst_N;
    logic       key_start_N;
    logic       key_clear_N;
    logic       modulo_SW;
    logic [1:0] round_cnt;
    logic [1:0] state_LED;
    logic       done_LED;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    counter_ctrl_if tmr_if ();

    counter_ctrl #(
        .DB_CYCLES  (4),
        .CLR_CYCLES (3),
        .MAX_ROUNDS (2)
    ) dut (
        .clk         (clk),
        .rst_N       (rst_N),
        .key_start_N (key_start_N),
        .key_clear_N (key_clear_N),
        .modulo_SW   (modulo_SW),
        .tmr         (tmr_if.master),
        .round_cnt   (round_cnt),
        .state_LED   (state_LED),
        .done_LED    (done_LED),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_start(input int n_low);
        key_start_N = 1'b0;
        wait_ticks(n_low);
        key_start_N = 1'b1;
        wait_ticks(12);
    endtask

    task automatic press_clear(input int n_low);
        key_clear_N = 1'b0;
        wait_ticks(n_low);
        key_clear_N = 1'b1;
        wait_ticks(12);
    endtask

    task automatic press_both(input int n_low);
        key_start_N = 1'b0;
        key_clear_N = 1'b0;
        wait_ticks(n_low);
        key_start_N = 1'b1;
        key_clear_N = 1'b1;
        wait_ticks(12);
    endtask

    task automatic pulse_wrap();
        tmr_if.wrap_pulse = 1'b1;
        tick();
        tmr_if.wrap_pulse = 1'b0;
        tick();
    endtask

    // Start press with wrap_pulse placed on the cycle the start event is
    // seen by the FSM: key low at edge 0, event pulse after edge 6, FSM
    // samples it at edge 7.
    task automatic start_with_wrap();
        key_start_N = 1'b0;
        wait_ticks(6);
        tmr_if.wrap_pulse = 1'b1;
        tick();
        tmr_if.wrap_pulse = 1'b0;
        key_start_N = 1'b1;
        wait_ticks(12);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_N = 1'b0;
        key_start_N = 1'b1;
        key_clear_N = 1'b1;
        modulo_SW = 1'b0;
        tmr_if.wrap_pulse = 1'b0;
        wait_ticks(3);
        checks++; if (state_LED !== 2'd0) begin errors++; $display("FAIL reset_state_led: got %0d expected 0", state_LED); end
        checks++; if (tmr_if.timer_en !== 1'b0) begin errors++; $display("FAIL reset_timer_en: got %0b expected 0", tmr_if.timer_en); end
        checks++; if (tmr_if.timer_modulo !== 1'b0) begin errors++; $display("FAIL reset_timer_modulo: got %0b expected 0", tmr_if.timer_modulo); end
        checks++; if (tmr_if.timer_clr_N !== 1'b1) begin errors++; $display("FAIL reset_timer_clr_n: got %0b expected 1", tmr_if.timer_clr_N); end
        checks++; if (round_cnt !== 2'd0) begin errors++; $display("FAIL reset_round_cnt: got %0d expected 0", round_cnt); end
        checks++; if (done_LED !== 1'b0) begin errors++; $display("FAIL reset_done_led: got %0b expected 0", done_LED); end
        rst_N = 1'b1;
        wait_ticks(2);
    endtask

    task automatic test_bounce_start();
        modulo_SW = 1'b1;
        key_start_N = 1'b0; wait_ticks(2);
        key_start_N = 1'b1; wait_ticks(1);
        key_start_N = 1'b0; wait_ticks(2);
        key_start_N = 1'b1; wait_ticks(12);
        checks++; if (state_LED !== 2'd0) begin errors++; $display("FAIL bounce_state: got %0d expected 0", state_LED); end
        checks++; if (tmr_if.timer_en !== 1'b0) begin errors++; $display("FAIL bounce_timer_en: got %0b expected 0", tmr_if.timer_en); end
        press_start(6);
        checks++; if (state_LED !== 2'd1) begin errors++; $display("FAIL held_press_state: got %0d expected 1", state_LED); end
        checks++; if (tmr_if.timer_en !== 1'b1) begin errors++; $display("FAIL held_press_timer_en: got %0b expected 1", tmr_if.timer_en); end
        checks++; if (tmr_if.timer_modulo !== 1'b1) begin errors++; $display("FAIL start_modulo_latch: got %0b expected 1", tmr_if.timer_modulo); end
    endtask

    task automatic test_modulo_hold();
        modulo_SW = 1'b0;
        wait_ticks(8);
        checks++; if (tmr_if.timer_modulo !== 1'b1) begin errors++; $display("FAIL modulo_hold_run: got %0b expected 1", tmr_if.timer_modulo); end
        checks++; if (state_LED !== 2'd1) begin errors++; $display("FAIL modulo_hold_state: got %0d expected 1", state_LED); end
    endtask

    task automatic test_wrap_done();
        pulse_wrap();
        checks++; if (round_cnt !== 2'd1) begin errors++; $display("FAIL wrap1_round: got %0d expected 1", round_cnt); end
        checks++; if (state_LED !== 2'd1) begin errors++; $display("FAIL wrap1_state: got %0d expected 1", state_LED); end
        pulse_wrap();
        checks++; if (round_cnt !== 2'd2) begin errors++; $display("FAIL wrap2_round: got %0d expected 2", round_cnt); end
        checks++; if (state_LED !== 2'd3) begin errors++; $display("FAIL wrap2_state: got %0d expected 3", state_LED); end
        checks++; if (tmr_if.timer_en !== 1'b0) begin errors++; $display("FAIL done_timer_en: got %0b expected 0", tmr_if.timer_en); end
        checks++; if (done_LED !== 1'b1) begin errors++; $display("FAIL done_led: got %0b expected 1", done_LED); end
        press_start(6);
        checks++; if (state_LED !== 2'd3) begin errors++; $display("FAIL done_ignore_start: got %0d expected 3", state_LED); end
        pulse_wrap();
        checks++; if (round_cnt !== 2'd2) begin errors++; $display("FAIL done_ignore_wrap: got %0d expected 2", round_cnt); end
    endtask

    task automatic test_clear_pause();
        int  low_cycles;
        bit  found;
        press_clear(6);
        checks++; if (state_LED !== 2'd0) begin errors++; $display("FAIL clear_from_done_state: got %0d expected 0", state_LED); end
        checks++; if (round_cnt !== 2'd0) begin errors++; $display("FAIL clear_from_done_round: got %0d expected 0", round_cnt); end
        checks++; if (done_LED !== 1'b0) begin errors++; $display("FAIL clear_from_done_led: got %0b expected 0", done_LED); end
        press_start(6);
        pulse_wrap();
        press_start(6);
        checks++; if (state_LED !== 2'd2) begin errors++; $display("FAIL pause_state: got %0d expected 2", state_LED); end
        checks++; if (tmr_if.timer_en !== 1'b0) begin errors++; $display("FAIL pause_timer_en: got %0b expected 0", tmr_if.timer_en); end
        pulse_wrap();
        checks++; if (round_cnt !== 2'd1) begin errors++; $display("FAIL pause_ignore_wrap: got %0d expected 1", round_cnt); end

        key_clear_N = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tmr_if.timer_clr_N === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL clear_pulse_seen: got %0b expected 1", found); end
        checks++; if (round_cnt !== 2'd0) begin errors++; $display("FAIL clear_round_zero: got %0d expected 0", round_cnt); end
        checks++; if (state_dbg !== 3'd4) begin errors++; $display("FAIL clear_state_dbg: got %0d expected 4", state_dbg); end
        checks++; if (state_LED !== 2'd0) begin errors++; $display("FAIL clear_state_led: got %0d expected 0", state_LED); end
        low_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (tmr_if.timer_clr_N !== 1'b0) break;
            low_cycles++;
            tick();
        end
        checks++; if (low_cycles !== 3) begin errors++; $display("FAIL clear_pulse_len: got %0d expected 3", low_cycles); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL clear_to_idle: got %0d expected 0", state_dbg); end
        key_clear_N = 1'b1;
        wait_ticks(12);
    endtask

    task automatic test_simultaneous();
        press_start(6);
        checks++; if (state_LED !== 2'd1) begin errors++; $display("FAIL sim_pre_run: got %0d expected 1", state_LED); end
        press_both(6);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL sim_clear_wins: got %0d expected 0", state_dbg); end
        checks++; if (tmr_if.timer_en !== 1'b0) begin errors++; $display("FAIL sim_clear_timer_en: got %0b expected 0", tmr_if.timer_en); end
        press_start(6);
        start_with_wrap();
        checks++; if (round_cnt !== 2'd1) begin errors++; $display("FAIL wrap_start_round: got %0d expected 1", round_cnt); end
        checks++; if (state_LED !== 2'd2) begin errors++; $display("FAIL wrap_start_pause: got %0d expected 2", state_LED); end
        press_start(6);
        checks++; if (state_LED !== 2'd1) begin errors++; $display("FAIL resume_run: got %0d expected 1", state_LED); end
        start_with_wrap();
        checks++; if (round_cnt !== 2'd2) begin errors++; $display("FAIL wrap_start_max_round: got %0d expected 2", round_cnt); end
        checks++; if (state_LED !== 2'd3) begin errors++; $display("FAIL wrap_start_done: got %0d expected 3", state_LED); end
    endtask

    task automatic test_reset_mid_clear();
        bit found;
        int clr_glitches;
        key_clear_N = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tmr_if.timer_clr_N === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_clear_entered: got %0b expected 1", found); end
        tick();
        rst_N = 1'b0;
        #2;
        checks++; if (tmr_if.timer_clr_N !== 1'b1) begin errors++; $display("FAIL rst_mid_clear_clr_n: got %0b expected 1", tmr_if.timer_clr_N); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_mid_clear_state: got %0d expected 0", state_dbg); end
        checks++; if (done_LED !== 1'b0) begin errors++; $display("FAIL rst_mid_clear_done: got %0b expected 0", done_LED); end
        key_clear_N = 1'b1;
        @(negedge clk);
        rst_N = 1'b1;
        clr_glitches = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (tmr_if.timer_clr_N !== 1'b1) clr_glitches++;
        end
        checks++; if (clr_glitches !== 0) begin errors++; $display("FAIL rst_no_spurious_clear: got %0d expected 0", clr_glitches); end

        // Reset in the middle of a start debounce.
        key_start_N = 1'b0;
        wait_ticks(4);
        rst_N = 1'b0;
        #2;
        key_start_N = 1'b1;
        @(negedge clk);
        rst_N = 1'b1;
        wait_ticks(15);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_no_spurious_start: got %0d expected 0", state_dbg); end
        press_start(6);
        checks++; if (state_LED !== 2'd1) begin errors++; $display("FAIL fresh_press_after_rst: got %0d expected 1", state_LED); end
        checks++; if (tmr_if.timer_modulo !== 1'b0) begin errors++; $display("FAIL fresh_press_modulo: got %0b expected 0", tmr_if.timer_modulo); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_bounce_start();
        test_modulo_hold();
        test_wrap_done();
        test_clear_pause();
        test_simultaneous();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
